// File: rtl/ctrlport_timeout_buffer.sv
// ctrlport_timeout_buffer: CTRL Port request FIFO that issues one request at a time and synthesises a response on timeout.
module ctrlport_timeout_buffer #(
  parameter int         DEPTH       = 8,
  parameter int         TIMEOUT     = 1024,
  parameter logic [1:0] TIMEOUT_STS = 2'b01,
  parameter int         CNT_W       = 16
) (
  input  logic                       ctrlport_clk,
  input  logic                       ctrlport_rst,
  input  logic                       s_ctrlport_req_wr,
  input  logic                       s_ctrlport_req_rd,
  input  logic [19:0]                s_ctrlport_req_addr,
  input  logic [9:0]                 s_ctrlport_req_portid,
  input  logic [15:0]                s_ctrlport_req_rem_epid,
  input  logic [9:0]                 s_ctrlport_req_rem_portid,
  input  logic [31:0]                s_ctrlport_req_data,
  input  logic [3:0]                 s_ctrlport_req_byte_en,
  input  logic                       s_ctrlport_req_has_time,
  input  logic [63:0]                s_ctrlport_req_time,
  output logic                       s_ctrlport_resp_ack,
  output logic [1:0]                 s_ctrlport_resp_status,
  output logic [31:0]                s_ctrlport_resp_data,
  output logic                       m_ctrlport_req_wr,
  output logic                       m_ctrlport_req_rd,
  output logic [19:0]                m_ctrlport_req_addr,
  output logic [9:0]                 m_ctrlport_req_portid,
  output logic [15:0]                m_ctrlport_req_rem_epid,
  output logic [9:0]                 m_ctrlport_req_rem_portid,
  output logic [31:0]                m_ctrlport_req_data,
  output logic [3:0]                 m_ctrlport_req_byte_en,
  output logic                       m_ctrlport_req_has_time,
  output logic [63:0]                m_ctrlport_req_time,
  input  logic                       m_ctrlport_resp_ack,
  input  logic [1:0]                 m_ctrlport_resp_status,
  input  logic [31:0]                m_ctrlport_resp_data,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [CNT_W-1:0]           overflow_cnt,
  output logic [CNT_W-1:0]           timeout_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam int RW = 159;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  logic [RW-1:0] s_word, req_q, req_d;
  logic [RW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [1:0] state_q, state_d, sts_q, sts_d;
  logic [TW-1:0] wcnt_q, wcnt_d;
  logic [31:0] dat_q, dat_d;
  logic [CNT_W-1:0] ovf_q, ovf_d, tmo_q, tmo_d;
  logic ack_q, ack_d, req_v, full, push, pop, expire, done, wr_l, rd_l;
  assign s_word = {s_ctrlport_req_wr, s_ctrlport_req_rd, s_ctrlport_req_addr, s_ctrlport_req_portid,
                   s_ctrlport_req_rem_epid, s_ctrlport_req_rem_portid, s_ctrlport_req_data,
                   s_ctrlport_req_byte_en, s_ctrlport_req_has_time, s_ctrlport_req_time};
  always_comb begin
    req_v   = s_ctrlport_req_wr | s_ctrlport_req_rd;
    full    = level_q == LW'(DEPTH);
    push    = req_v && !full;
    // one idle cycle after each response before the next pop
    pop     = state_q == IDLE && level_q != '0 && !ack_q;
    expire  = TIMEOUT != 0 && wcnt_q == TW'(TIMEOUT - 1);
    done    = state_q == WAIT && (m_ctrlport_resp_ack || expire);
    wptr_d  = wptr_q + AW'(push);
    rptr_d  = rptr_q + AW'(pop);
    level_d = level_q + LW'(push) - LW'(pop);
    req_d   = pop ? mem_q[rptr_q] : req_q;
    state_d = pop ? ISSUE : state_q == ISSUE ? WAIT : done ? IDLE : state_q;
    wcnt_d  = state_q == WAIT ? wcnt_q + 1'b1 : '0;
    ack_d   = done;
    sts_d   = !done ? 2'b00 : m_ctrlport_resp_ack ? m_ctrlport_resp_status : TIMEOUT_STS;
    dat_d   = done && m_ctrlport_resp_ack ? m_ctrlport_resp_data : 32'd0;
    ovf_d   = ovf_q + CNT_W'(req_v && full && !(&ovf_q));
    tmo_d   = tmo_q + CNT_W'(done && !m_ctrlport_resp_ack && !(&tmo_q));
  end
  always_ff @(posedge ctrlport_clk) begin
    if (ctrlport_rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      req_q   <= '0;
      state_q <= IDLE;
      wcnt_q  <= '0;
      ack_q   <= 1'b0;
      sts_q   <= '0;
      dat_q   <= '0;
      ovf_q   <= '0;
      tmo_q   <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      req_q   <= req_d;
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      ack_q   <= ack_d;
      sts_q   <= sts_d;
      dat_q   <= dat_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
    end
  end
  always_ff @(posedge ctrlport_clk) begin
    if (push) mem_q[wptr_q] <= s_word;
  end
  assign {wr_l, rd_l, m_ctrlport_req_addr, m_ctrlport_req_portid, m_ctrlport_req_rem_epid,
          m_ctrlport_req_rem_portid, m_ctrlport_req_data, m_ctrlport_req_byte_en,
          m_ctrlport_req_has_time, m_ctrlport_req_time} = req_q;
  assign m_ctrlport_req_wr      = state_q == ISSUE && wr_l;
  assign m_ctrlport_req_rd      = state_q == ISSUE && rd_l;
  assign s_ctrlport_resp_ack    = ack_q;
  assign s_ctrlport_resp_status = sts_q;
  assign s_ctrlport_resp_data   = dat_q;
  assign fifo_level             = level_q;
  assign overflow_cnt           = ovf_q;
  assign timeout_cnt            = tmo_q;
endmodule

// File: tb/tb_ctrlport_timeout_buffer.sv
// tb_ctrlport_timeout_buffer: directed checks of queuing, issue latency, timeout, overflow and reset.
module tb_ctrlport_timeout_buffer;
  logic clk = 1'b0, rst = 1'b1;
  logic s_wr = 0, s_rd = 0, s_has_time = 0;
  logic [19:0] s_addr = 0;
  logic [9:0] s_portid = 0, s_rem_portid = 0;
  logic [15:0] s_rem_epid = 0;
  logic [31:0] s_data = 0;
  logic [3:0] s_byte_en = 0;
  logic [63:0] s_time = 0;
  logic r_ack, m_wr, m_rd, m_has_time;
  logic [1:0] r_sts;
  logic [31:0] r_data, m_data;
  logic [19:0] m_addr;
  logic [9:0] m_portid, m_rem_portid;
  logic [15:0] m_rem_epid;
  logic [3:0] m_byte_en;
  logic [63:0] m_time;
  logic a_ack = 0;
  logic [1:0] a_sts = 0;
  logic [31:0] a_data = 0;
  logic [3:0] level;
  logic [15:0] ovf_cnt, tmo_cnt;
  int tests = 0, fails = 0;
  logic [33:0] rq[$];
  always #5 clk = ~clk;
  ctrlport_timeout_buffer #(.DEPTH(8), .TIMEOUT(16), .TIMEOUT_STS(2'b01), .CNT_W(16)) dut (
    .ctrlport_clk(clk), .ctrlport_rst(rst),
    .s_ctrlport_req_wr(s_wr), .s_ctrlport_req_rd(s_rd), .s_ctrlport_req_addr(s_addr),
    .s_ctrlport_req_portid(s_portid), .s_ctrlport_req_rem_epid(s_rem_epid),
    .s_ctrlport_req_rem_portid(s_rem_portid), .s_ctrlport_req_data(s_data),
    .s_ctrlport_req_byte_en(s_byte_en), .s_ctrlport_req_has_time(s_has_time),
    .s_ctrlport_req_time(s_time),
    .s_ctrlport_resp_ack(r_ack), .s_ctrlport_resp_status(r_sts), .s_ctrlport_resp_data(r_data),
    .m_ctrlport_req_wr(m_wr), .m_ctrlport_req_rd(m_rd), .m_ctrlport_req_addr(m_addr),
    .m_ctrlport_req_portid(m_portid), .m_ctrlport_req_rem_epid(m_rem_epid),
    .m_ctrlport_req_rem_portid(m_rem_portid), .m_ctrlport_req_data(m_data),
    .m_ctrlport_req_byte_en(m_byte_en), .m_ctrlport_req_has_time(m_has_time),
    .m_ctrlport_req_time(m_time),
    .m_ctrlport_resp_ack(a_ack), .m_ctrlport_resp_status(a_sts), .m_ctrlport_resp_data(a_data),
    .fifo_level(level), .overflow_cnt(ovf_cnt), .timeout_cnt(tmo_cnt)
  );
  always @(negedge clk) if (r_ack) rq.push_back({r_sts, r_data});
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic wr, input logic rd, input logic [19:0] addr, input logic [31:0] data);
    s_wr = wr; s_rd = rd; s_addr = addr; s_data = data;
    s_portid = 10'h155; s_byte_en = 4'hF; s_has_time = 1'b1; s_time = 64'h1234;
    tick();
    s_wr = 0; s_rd = 0;
  endtask
  task automatic wait_issue(input string tag);
    int n = 0;
    while (!(m_wr || m_rd) && n < 50) begin
      tick();
      n++;
    end
    chk(tag, 64'(n < 50), 64'd1);
  endtask
  task automatic ack_now(input logic [31:0] d);
    a_ack = 1; a_sts = 2'b00; a_data = d;
    tick();
    a_ack = 0; a_data = 0;
  endtask
  initial begin
    logic bad;
    repeat (3) tick();
    rst = 0;
    chk("rst_ack", 64'(r_ack), 0);
    chk("rst_mwr", 64'(m_wr | m_rd), 0);
    chk("rst_addr", 64'(m_addr), 0);
    chk("rst_level", 64'(level), 0);
    chk("rst_ovf", 64'(ovf_cnt), 0);
    chk("rst_tmo", 64'(tmo_cnt), 0);
    // single write: issue at N+2, ack 3 cycles after issue, response one cycle later
    send(1, 0, 20'h00010, 32'hDEADBEEF);
    chk("wr_n1", 64'(m_wr), 0);
    tick();
    chk("wr_n2", 64'(m_wr), 1);
    chk("wr_addr", 64'(m_addr), 64'h10);
    chk("wr_data", 64'(m_data), 64'hDEADBEEF);
    chk("wr_portid", 64'(m_portid), 64'h155);
    chk("wr_time", m_time, 64'h1234);
    chk("wr_be", 64'(m_byte_en), 64'hF);
    tick();
    chk("wr_pulse", 64'(m_wr), 0);
    tick();
    tick();
    ack_now(32'h0);
    chk("wr_resp_ack", 64'(r_ack), 1);
    chk("wr_resp_sts", 64'(r_sts), 0);
    chk("wr_addr_hold", 64'(m_addr), 64'h10);
    tick();
    chk("wr_resp_single", 64'(r_ack), 0);
    // read returns target data
    send(0, 1, 20'h00020, 32'h0);
    wait_issue("rd_issue");
    chk("rd_rd", 64'(m_rd), 1);
    chk("rd_wr", 64'(m_wr), 0);
    chk("rd_addr", 64'(m_addr), 64'h20);
    tick();
    ack_now(32'h12345678);
    chk("rd_ack", 64'(r_ack), 1);
    chk("rd_data", 64'(r_data), 64'h12345678);
    chk("rd_sts", 64'(r_sts), 0);
    // timeout: response exactly 17 cycles after issue
    send(1, 0, 20'h00040, 32'h1);
    wait_issue("to_issue");
    bad = 0;
    repeat (16) begin
      tick();
      bad |= r_ack;
    end
    chk("to_early", 64'(bad), 0);
    tick();
    chk("to_ack", 64'(r_ack), 1);
    chk("to_sts", 64'(r_sts), 64'h1);
    chk("to_data", 64'(r_data), 0);
    chk("to_cnt", 64'(tmo_cnt), 1);
    a_ack = 1; a_sts = 2'b10; a_data = 32'hFFFF;
    tick();
    a_ack = 0; a_sts = 0; a_data = 0;
    rq.delete();
    repeat (3) tick();
    chk("stray_ignored", 64'(rq.size()), 0);
    // ack on the final wait cycle beats the timeout
    send(1, 0, 20'h00044, 32'h2);
    wait_issue("race_issue");
    repeat (16) tick();
    ack_now(32'hA5A5A5A5);
    chk("race_ack", 64'(r_ack), 1);
    chk("race_sts", 64'(r_sts), 0);
    chk("race_data", 64'(r_data), 64'hA5A5A5A5);
    chk("race_tmo", 64'(tmo_cnt), 1);
    tick();
    // overflow: 1 in flight, 8 queued, 1 dropped
    rq.delete();
    for (int i = 0; i < 10; i++) send(1, 0, 20'(i), 32'(i));
    chk("ovf_level", 64'(level), 8);
    chk("ovf_cnt", 64'(ovf_cnt), 1);
    ack_now({12'h0, m_addr});
    for (int i = 0; i < 8; i++) begin
      wait_issue("ovf_issue");
      tick();
      ack_now({12'h0, m_addr});
    end
    repeat (5) tick();
    chk("ovf_nresp", 64'(rq.size()), 9);
    for (int i = 0; i < 9; i++) chk("ovf_order", i < rq.size() ? 64'(rq[i]) : '1, 64'(i));
    chk("ovf_drain", 64'(level), 0);
    chk("ovf_tmo", 64'(tmo_cnt), 1);
    // reset during WAIT with 3 queued
    rq.delete();
    for (int i = 0; i < 4; i++) send(1, 0, 20'h50 + 20'(i), 32'(i));
    tick();
    tick();
    chk("rstw_level_pre", 64'(level), 3);
    rst = 1;
    tick();
    rst = 0;
    chk("rstw_level", 64'(level), 0);
    chk("rstw_addr", 64'(m_addr), 0);
    chk("rstw_ovf", 64'(ovf_cnt), 0);
    chk("rstw_tmo", 64'(tmo_cnt), 0);
    ack_now(32'h77);
    bad = 0;
    repeat (20) begin
      tick();
      bad |= m_wr | m_rd;
    end
    chk("rstw_no_issue", 64'(bad), 0);
    chk("rstw_no_resp", 64'(rq.size()), 0);
    send(0, 1, 20'h00060, 32'h0);
    wait_issue("rstw_issue");
    chk("rstw_new_addr", 64'(m_addr), 64'h60);
    tick();
    ack_now(32'hCAFEF00D);
    chk("rstw_new_ack", 64'(r_ack), 1);
    chk("rstw_new_data", 64'(r_data), 64'hCAFEF00D);
    tick();
    chk("rstw_new_nresp", 64'(rq.size()), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
